// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem, presents instructions valid/ready.
// Issue-to-valid latency 2 cycles; a stalled output with a read in flight holds issue, return lands in a 1-entry skid.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        pc_plus4
);

  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_dat;
  logic [31:0] skid_pc;
  logic        issue;
  logic        consume;

  // A stalled output with a read already outstanding leaves exactly one free slot (the skid),
  // so no further read may be issued until the datapath drains.
  assign issue = !rst && !halt && !redirect_valid && !skid_valid &&
                 !(instr_valid && !instr_ready && inflight);
  assign consume   = instr_valid && instr_ready;
  assign imem_en   = issue;
  assign imem_addr = rst ? '0 : pc[IMEM_AW+1:2];
  assign pc_plus4  = instr_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_dat    <= '0;
      skid_pc     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over any handshake or returning read this cycle.
      pc          <= redirect_target & ~32'd3;
      inflight    <= 1'b0;
      skid_valid  <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end

      if (consume && skid_valid) begin
        instr_valid <= 1'b1;
        instr       <= skid_dat;
        instr_pc    <= skid_pc;
        skid_valid  <= inflight;
        if (inflight) begin
          skid_dat <= imem_rdata;
          skid_pc  <= inflight_pc;
        end
      end else if (consume || !instr_valid) begin
        instr_valid <= inflight;
        if (inflight) begin
          instr    <= imem_rdata;
          instr_pc <= inflight_pc;
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_dat   <= imem_rdata;
        skid_pc    <= inflight_pc;
      end
    end
  end

endmodule
